// File: rtl/bus_ram_responder.sv
// Single-port 32-bit word RAM acting as a request/ready target on the CPU data bus.
// Optional range check enabled by defining BUS_RAM_RANGE_CHECK_EN.
//
// Handshake: the initiator raises i_request and holds i_rw/i_address/i_wdata stable
// until it sees o_ready, a single-cycle completion pulse. Request fields are latched
// on acceptance in IDLE. i_request is ignored during the READY cycle, so a request
// held high across transfers is taken as a new transfer in the following IDLE cycle.
module bus_ram_responder #(
    parameter int          ADDR_WIDTH   = 12,
    parameter int          WAIT_STATES  = 0,
    parameter logic [31:0] BASE_ADDRESS = 32'h0,
    parameter string       INIT_FILE    = ""
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_request,
    input  logic        i_rw,
    input  logic [31:0] i_address,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata,
    output logic        o_ready,
    output logic        o_error,
    output logic [1:0]  o_state
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [7:0] WAIT_INIT = (WAIT_STATES > 0) ? 8'(WAIT_STATES - 1) : 8'd0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_READY  = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [7:0]              cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
    logic                    rw_q, rw_d;
    logic [31:0]             wdata_q, wdata_d;
    logic                    err_q, err_d;
    logic [31:0]             rdata_q;
    logic                    ready_q, ready_d;
    logic                    error_q, error_d;
    logic                    mem_we;
    logic                    mem_re;
    logic                    oor_req;
    logic                    unused_addr_lo;

    logic [31:0] mem [0:DEPTH-1];

    assign unused_addr_lo = ^i_address[1:0];

`ifdef BUS_RAM_RANGE_CHECK_EN
    localparam logic [32:0] SPAN     = 33'd4 << ADDR_WIDTH;
    localparam logic [32:0] BASE_EXT = {1'b0, BASE_ADDRESS};
    logic [32:0] addr_ext;

    assign addr_ext = {1'b0, i_address[31:2], 2'b00};
    assign oor_req  = (addr_ext < BASE_EXT) || (addr_ext >= BASE_EXT + SPAN);
`else
    // Without the check, upper address bits simply alias onto the array.
    logic unused_cfg;
    assign unused_cfg = ^{BASE_ADDRESS, i_address[31:ADDR_WIDTH+2]};
    assign oor_req    = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        rw_d    = rw_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        ready_d = 1'b0;
        error_d = 1'b0;
        mem_we  = 1'b0;
        mem_re  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_request) begin
                    idx_d   = i_address[ADDR_WIDTH+1:2];
                    rw_d    = i_rw;
                    wdata_d = i_wdata;
                    err_d   = oor_req;
                    if (WAIT_STATES > 0) begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_INIT;
                    end else begin
                        state_d = ST_ACCESS;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 8'd0) begin
                    state_d = ST_ACCESS;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_ACCESS: begin
                ready_d = 1'b1;
                error_d = err_q;
                mem_we  = rw_q & ~err_q;
                mem_re  = ~rw_q;
                state_d = ST_READY;
            end
            ST_READY: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'd0;
            idx_q   <= '0;
            rw_q    <= 1'b0;
            wdata_q <= 32'h0;
            err_q   <= 1'b0;
            rdata_q <= 32'h0;
            ready_q <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            rw_q    <= rw_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            ready_q <= ready_d;
            error_q <= error_d;
            if (mem_re) begin
                rdata_q <= err_q ? 32'h0 : mem[idx_q];
            end
        end
    end

    // mem_we depends on state_q, which reset clears at once, so an aborted write never lands.
    always_ff @(posedge i_clock) begin
        if (mem_we) begin
            mem[idx_q] <= wdata_q;
        end
    end

    assign o_rdata = rdata_q;
    assign o_ready = ready_q;
    assign o_error = error_q;
    assign o_state = state_q;

endmodule

// File: tb/tb_bus_ram_responder.sv
// Bench for bus_ram_responder: one instance with no wait states, one with three,
// table vectors, hand-timed corner sequences and a random run against a word-map model.
module tb_bus_ram_responder;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       req;
  logic [1:0]       rw;
  logic [1:0][31:0] addr;
  logic [1:0][31:0] wdata;
  logic [1:0][31:0] rdata;
  logic [1:0]       ready;
  logic [1:0]       error;
  logic [1:0][1:0]  st;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] exp_q[$];
  logic [31:0] model[int];

`ifdef BUS_RAM_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  typedef struct {
    bit          w;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    bit          exp_err;
  } vec_t;

  vec_t vecs[8];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  bus_ram_responder #(.ADDR_WIDTH(12), .WAIT_STATES(0), .BASE_ADDRESS(32'h0), .INIT_FILE("")) dut0 (
    .i_clock(clk), .i_reset(rst), .i_request(req[0]), .i_rw(rw[0]),
    .i_address(addr[0]), .i_wdata(wdata[0]), .o_rdata(rdata[0]),
    .o_ready(ready[0]), .o_error(error[0]), .o_state(st[0])
  );

  bus_ram_responder #(.ADDR_WIDTH(12), .WAIT_STATES(3), .BASE_ADDRESS(32'h0), .INIT_FILE("")) dut3 (
    .i_clock(clk), .i_reset(rst), .i_request(req[1]), .i_rw(rw[1]),
    .i_address(addr[1]), .i_wdata(wdata[1]), .o_rdata(rdata[1]),
    .o_ready(ready[1]), .o_error(error[1]), .o_state(st[1])
  );

  // ---------------- reference model ----------------
  function automatic bit ref_in_range(input logic [31:0] a);
    if (RC) return (a >> 2) < 32'd4096;
    return 1'b1;
  endfunction

  function automatic int ref_key(input int d, input logic [31:0] a);
    return d * 65536 + int'((a >> 2) % 32'd4096);
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Called just after a rising edge; returns just after a rising edge with the DUT idle.
  task automatic run_xfer(input int d, input bit w, input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output logic er);
    int  key;
    bit  inr;
    bit  has_exp;
    bit  ok;
    int  lat;
    int  exp_lat;
    logic [31:0] e;
    inr     = ref_in_range(a);
    key     = ref_key(d, a);
    exp_lat = (d == 0) ? 2 : 5;
    has_exp = 1'b0;
    if (!w) begin
      if (!inr) begin
        exp_q.push_back(32'h0);
        has_exp = 1'b1;
      end else if (model.exists(key)) begin
        exp_q.push_back(model[key]);
        has_exp = 1'b1;
      end
    end
    req[d] = 1'b1; rw[d] = w; addr[d] = a; wdata[d] = wd;
    ok = 1'b0; lat = 0; rd = 32'h0; er = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (ready[d]) begin
        ok = 1'b1; lat = c; rd = rdata[d]; er = error[d];
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    req[d] = 1'b0;
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL xfer_timeout: got no o_ready in 40 cycles, expected one (dut %0d addr %h)", d, a);
    end else begin
      check("xfer_latency", lat, exp_lat);
    end
    check("xfer_error", er, !inr);
    if (has_exp) begin
      e = exp_q.pop_front();
      check("xfer_rdata", rd, e);
    end
    if (w && inr) model[key] = wd;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] rd;
    logic        er;
    logic [31:0] a;
    int          d;
    int          idx;
    bit          w;

    vecs[0] = '{1'b1, 32'h10,   32'hCAFEBABE, 32'h0,        1'b0};
    vecs[1] = '{1'b0, 32'h10,   32'h0,        32'hCAFEBABE, 1'b0};
    vecs[2] = '{1'b1, 32'h10,   32'h55AA55AA, 32'h0,        1'b0};
    vecs[3] = '{1'b0, 32'h13,   32'h0,        32'h55AA55AA, 1'b0};
    vecs[4] = '{1'b1, 32'h0,    32'h0,        32'h0,        1'b0};
    vecs[5] = '{1'b1, 32'h4000, 32'hDEADBEEF, 32'h0,        RC};
    vecs[6] = '{1'b0, 32'h0,    32'h0,        RC ? 32'h0 : 32'hDEADBEEF, 1'b0};
    vecs[7] = '{1'b0, 32'h4000, 32'h0,        RC ? 32'h0 : 32'hDEADBEEF, RC};

    rst = 1'b1; req = '0; rw = '0; addr = '0; wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("reset_ready", ready[i], 1'b0);
      check("reset_error", error[i], 1'b0);
      check("reset_rdata", rdata[i], 32'h0);
      check("reset_state", st[i], 2'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // table vectors on the zero-wait instance
    for (int i = 0; i < 8; i++) begin
      run_xfer(0, vecs[i].w, vecs[i].a, vecs[i].wd, rd, er);
      if (!vecs[i].w) check("tbl_rdata", rd, vecs[i].exp_rd);
      check("tbl_error", er, vecs[i].exp_err);
    end

    // read-modify-write with request held high throughout
    run_xfer(0, 1'b1, 32'h20, 32'h01020304, rd, er);
    req[0] = 1'b1; rw[0] = 1'b0; addr[0] = 32'h20; wdata[0] = 32'h0;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      check("rmw_ready", ready[0], (c == 2 || c == 5));
      if (c == 2 || c == 5) check("rmw_rdata", rdata[0], 32'h01020304);
      @(posedge clk); #1;
      if (c == 2) begin
        rw[0] = 1'b1;
        wdata[0] = 32'h11223344;
      end
      if (c == 5) req[0] = 1'b0;
    end
    model[ref_key(0, 32'h20)] = 32'h11223344;
    run_xfer(0, 1'b0, 32'h20, 32'h0, rd, er);

    // three wait states: ready only in cycle 5
    run_xfer(1, 1'b1, 32'h30, 32'h0, rd, er);
    req[1] = 1'b1; rw[1] = 1'b0; addr[1] = 32'h30;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      check("ws3_ready", ready[1], (c == 5));
      if (c == 5) check("ws3_rdata", rdata[1], 32'h0);
      @(posedge clk); #1;
      if (c == 5) req[1] = 1'b0;
    end

    // reset during WAIT aborts the write
    req[1] = 1'b1; rw[1] = 1'b1; addr[1] = 32'h30; wdata[1] = 32'hAAAA5555;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    req[1] = 1'b0;
    #1;
    check("rst_ready", ready[1], 1'b0);
    check("rst_state", st[1], 2'd0);
    check("rst_rdata_async", rdata[0], 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_xfer(1, 1'b0, 32'h30, 32'h0, rd, er);

    // randomized traffic against the word-map model
    for (int i = 0; i < 40; i++) begin
      d   = int'($urandom_range(0, 1));
      idx = int'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) idx = idx + 4096;
      a = 32'(idx * 4) | 32'($urandom_range(0, 3));
      w = 1'($urandom_range(0, 1));
      if (!w && ref_in_range(a) && !model.exists(ref_key(d, a))) w = 1'b1;
      run_xfer(d, w, a, $urandom, rd, er);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
